// File: rtl/if_id_buffer_if.sv
// Beat channel between fetch and decode: valid/ready handshake with one
// instruction beat. The master drives the beat, the slave drives ready.
interface if_id_beat_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        decompress_failed;
    logic        is_cond_branch;

    modport master (
        output valid, pc, instr, decompress_failed, is_cond_branch,
        input  ready
    );

    modport slave (
        input  valid, pc, instr, decompress_failed, is_cond_branch,
        output ready
    );
endinterface

// File: rtl/if_id_buffer.sv
// ID-side receiver of the IF/ID link: small in-order FIFO from fetch to decode
// with flush, halt detection and retire / decompress-fail counters.
module if_id_buffer #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
    parameter int          FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    if_id_beat_if.slave       f,
    if_id_beat_if.master      d,
    input  logic              if_id_flush,
    output logic              run_finished_next,
    output logic              run_finished,
    output logic [31:0]       retire_cnt,
    output logic [FCNT_W-1:0] decomp_fail_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        dfail;
        logic        cbr;
    } beat_t;

    beat_t          mem [DEPTH];
    beat_t          head;
    beat_t          beat_in;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;

    // rstn is active-high here: every handshake output is forced off while it is asserted.
    assign f.ready = (count < CW'(DEPTH)) && !run_finished && !rstn;
    assign d.valid = (count != '0) && !if_id_flush && !run_finished && !rstn;

    assign head    = rstn ? '0 : mem[rd_ptr];
    assign beat_in = '{pc: f.pc, instr: f.instr, dfail: f.decompress_failed,
                       cbr: f.is_cond_branch};

    assign d.pc                = head.pc;
    assign d.instr             = head.instr;
    assign d.decompress_failed = head.dfail;
    assign d.is_cond_branch    = head.cbr;

    assign push = f.valid && f.ready && !if_id_flush;
    assign pop  = d.valid && d.ready;

    assign run_finished_next = pop && (head.instr == HALT_INSTR);

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            run_finished    <= 1'b0;
            retire_cnt      <= '0;
            decomp_fail_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (if_id_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= beat_in;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end

            // pop is already zero during a flush, so counters only move on real deliveries
            if (pop) begin
                retire_cnt <= retire_cnt + 32'd1;
                if (head.dfail && !(&decomp_fail_cnt))
                    decomp_fail_cnt <= decomp_fail_cnt + 1'b1;
                if (run_finished_next) run_finished <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_if_id_buffer;
    localparam int          DEPTH  = 2;
    localparam int          FCNT_W = 4;
    localparam logic [31:0] HALT   = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              rfn;
    logic              rf;
    logic [31:0]       ret;
    logic [FCNT_W-1:0] fcnt;

    if_id_beat_if fch ();
    if_id_beat_if dec ();

    if_id_buffer #(.DEPTH(DEPTH), .HALT_INSTR(HALT), .FCNT_W(FCNT_W)) dut (
        .clk               (clk),
        .rstn              (rst),
        .f                 (fch),
        .d                 (dec),
        .if_id_flush       (flush),
        .run_finished_next (rfn),
        .run_finished      (rf),
        .retire_cnt        (ret),
        .decomp_fail_cnt   (fcnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: queue of beats plus sticky halt and counters
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        df;
        logic        cb;
    } mbeat_t;

    mbeat_t            q[$];
    bit                m_rf;
    logic [31:0]       m_ret;
    int                m_fcnt;
    bit                e_dv, e_fr;

    task automatic model_reset();
        q.delete();
        m_rf   = 0;
        m_ret  = 0;
        m_fcnt = 0;
    endtask

    task automatic apply(input logic r, input logic fv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic df, input logic cb,
                         input logic fl, input logic dr);
        bit e_rfn;
        rst = r; fch.valid = fv; fch.pc = pc; fch.instr = ins;
        fch.decompress_failed = df; fch.is_cond_branch = cb;
        flush = fl; dec.ready = dr;
        #1;
        e_fr  = !r && (q.size() < DEPTH) && !m_rf;
        e_dv  = !r && (q.size() != 0) && !fl && !m_rf;
        e_rfn = e_dv && dr && (q[0].instr == HALT);
        chk("m_f_ready", fch.ready, e_fr);
        chk("m_d_valid", dec.valid, e_dv);
        chk("m_rfn", rfn, e_rfn);
        chk("m_rf", rf, m_rf);
        chk("m_retire", ret, m_ret);
        chk("m_fcnt", fcnt, m_fcnt);
        if (e_dv) begin
            chk("m_pc", dec.pc, q[0].pc);
            chk("m_instr", dec.instr, q[0].instr);
            chk("m_df", dec.decompress_failed, q[0].df);
            chk("m_cb", dec.is_cond_branch, q[0].cb);
        end
        if (r) chk("m_pc_rst", dec.pc, 0);
    endtask

    task automatic adv();
        bit push, pop;
        mbeat_t hd;
        @(posedge clk);
        push = fch.valid && e_fr && !flush;
        pop  = e_dv && dec.ready;
        if (rst) model_reset();
        else begin
            hd = (q.size() != 0) ? q[0] : '0;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{fch.pc, fch.instr, fch.decompress_failed, fch.is_cond_branch});
            end
            if (pop) begin
                m_ret = m_ret + 1;
                if (hd.df && m_fcnt < (1 << FCNT_W) - 1) m_fcnt++;
                if (hd.instr == HALT) m_rf = 1;
            end
        end
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        rst, fv;
        logic [31:0] pc, instr;
        logic        df, fl, dr;
        logic        e_dv, e_fr;
        logic [31:0] e_pc;
        logic        e_rfn, e_rf;
        logic [31:0] e_ret;
    } vec_t;

    function automatic vec_t v(logic r, logic fv, logic [31:0] pc, logic [31:0] ins,
                               logic df, logic fl, logic dr, logic edv, logic efr,
                               logic [31:0] epc, logic erfn, logic erf, logic [31:0] eret);
        vec_t t;
        t = '{r, fv, pc, ins, df, fl, dr, edv, efr, epc, erfn, erf, eret};
        return t;
    endfunction

    vec_t vt[22];

    initial begin
        //           rst fv pc       instr df fl dr | dv fr pc     rfn rf ret
        vt[0]  = v(1, 1, 32'h100, NOP,  0, 0, 0,   0, 0, 0,       0, 0, 0);
        vt[1]  = v(0, 1, 32'h100, NOP,  0, 0, 1,   0, 1, 0,       0, 0, 0);
        vt[2]  = v(0, 0, 0,       NOP,  0, 0, 1,   1, 1, 32'h100, 0, 0, 0);
        vt[3]  = v(0, 0, 0,       NOP,  0, 0, 0,   0, 1, 0,       0, 0, 1);
        vt[4]  = v(0, 1, 32'h0,   NOP,  0, 0, 0,   0, 1, 0,       0, 0, 1);
        vt[5]  = v(0, 1, 32'h4,   NOP,  0, 0, 0,   1, 1, 32'h0,   0, 0, 1);
        vt[6]  = v(0, 1, 32'h8,   NOP,  0, 0, 0,   1, 0, 32'h0,   0, 0, 1);
        vt[7]  = v(0, 1, 32'h8,   NOP,  0, 0, 1,   1, 0, 32'h0,   0, 0, 1);
        vt[8]  = v(0, 1, 32'h8,   NOP,  0, 0, 1,   1, 1, 32'h4,   0, 0, 2);
        vt[9]  = v(0, 0, 0,       NOP,  0, 0, 1,   1, 1, 32'h8,   0, 0, 3);
        vt[10] = v(0, 0, 0,       NOP,  0, 0, 0,   0, 1, 0,       0, 0, 4);
        vt[11] = v(0, 1, 32'h10,  NOP,  0, 0, 0,   0, 1, 0,       0, 0, 4);
        vt[12] = v(0, 1, 32'h14,  NOP,  0, 0, 0,   1, 1, 32'h10,  0, 0, 4);
        vt[13] = v(0, 1, 32'h20,  NOP,  0, 1, 1,   0, 0, 0,       0, 0, 4);
        vt[14] = v(0, 0, 0,       NOP,  0, 0, 1,   0, 1, 0,       0, 0, 4);
        vt[15] = v(0, 1, 32'h40,  HALT, 0, 0, 0,   0, 1, 0,       0, 0, 4);
        vt[16] = v(0, 1, 32'h44,  NOP,  0, 0, 0,   1, 1, 32'h40,  0, 0, 4);
        vt[17] = v(0, 0, 0,       NOP,  0, 0, 1,   1, 0, 32'h40,  1, 0, 4);
        vt[18] = v(0, 1, 32'h48,  NOP,  0, 0, 1,   0, 0, 0,       0, 1, 5);
        vt[19] = v(0, 1, 32'h48,  NOP,  0, 0, 1,   0, 0, 0,       0, 1, 5);
        vt[20] = v(1, 0, 0,       NOP,  0, 0, 1,   0, 0, 0,       0, 1, 5);
        vt[21] = v(0, 0, 0,       NOP,  0, 0, 0,   0, 1, 0,       0, 0, 0);

        rst = 1; fch.valid = 0; fch.pc = 0; fch.instr = 0;
        fch.decompress_failed = 0; fch.is_cond_branch = 0; flush = 0; dec.ready = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        for (int i = 0; i < 22; i++) begin
            apply(vt[i].rst, vt[i].fv, vt[i].pc, vt[i].instr, vt[i].df, 1'b0, vt[i].fl, vt[i].dr);
            chk($sformatf("v%0d_d_valid", i), dec.valid, vt[i].e_dv);
            chk($sformatf("v%0d_f_ready", i), fch.ready, vt[i].e_fr);
            chk($sformatf("v%0d_rfn", i), rfn, vt[i].e_rfn);
            chk($sformatf("v%0d_rf", i), rf, vt[i].e_rf);
            chk($sformatf("v%0d_retire", i), ret, vt[i].e_ret);
            if (vt[i].e_dv) chk($sformatf("v%0d_pc", i), dec.pc, vt[i].e_pc);
            if (vt[i].rst)  chk($sformatf("v%0d_pc_rst", i), dec.pc, 0);
            adv();
        end

        // continuous push/pop at occupancy 1: no bubbles, pointers wrap
        apply(0, 1, 32'h200, NOP, 0, 0, 0, 0);
        adv();
        for (int k = 0; k < 10; k++) begin
            apply(0, 1, 32'h204 + 32'(4 * k), NOP, 0, 0, 0, 1);
            chk("cont_valid", dec.valid, 1);
            chk("cont_ready", fch.ready, 1);
            chk("cont_pc", dec.pc, 32'h200 + 32'(4 * k));
            adv();
        end
        apply(0, 0, 0, NOP, 0, 0, 0, 0);
        chk("cont_retire", ret, 10);
        chk("cont_occupancy", dec.valid, 1);
        adv();

        // decompress-fail counter saturates at all-ones
        apply(1, 0, 0, NOP, 0, 0, 0, 0);
        adv();
        for (int k = 0; k < 18; k++) begin
            apply(0, 1, 32'h300 + 32'(4 * k), NOP, 1, 0, 0, 1);
            adv();
        end
        apply(0, 0, 0, NOP, 0, 0, 0, 0);
        chk("sat_fcnt", fcnt, 4'hF);
        chk("sat_retire", ret, 17);
        adv();

        for (int n = 0; n < 3000; n++) begin
            apply(($urandom % 60) == 0, ($urandom % 4) != 0, $urandom,
                  (($urandom % 12) == 0) ? HALT : $urandom,
                  ($urandom % 3) == 0, 1'($urandom), ($urandom % 20) == 0,
                  ($urandom % 4) != 0);
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
